// File: rtl/operand_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_ctrl
// Description : Hazard and forwarding controller for a 4-stage RV64 integer
//               pipeline (ID -> EX -> MEM -> WB). It keeps a small record of
//               the destination register of each in-flight instruction, then
//               drives the registered 2-bit selects of the EX-stage operand
//               muxes. It also detects load-use hazards, stalls ID while
//               sending a bubble into EX, and counts stall cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk              in   pipeline clock, rising edge
//   rst              in   asynchronous active-high reset
//   pipe_en_i        in   global advance; 0 freezes all state
//   flush_i          in   kill the instructions in ID and EX
//   id_valid_i       in   ID holds a real instruction
//   id_rs1_i/rs2_i   in   source register indices
//   id_rs1_used_i    in   instruction reads rs1
//   id_rs2_used_i    in   instruction reads rs2
//   id_rd_i          in   destination register index
//   id_reg_write_i   in   instruction writes rd
//   id_mem_read_i    in   instruction is a load
//   fwd_sel_a_o      out  EX operand-A select (registered)
//   fwd_sel_b_o      out  EX operand-B select (registered)
//   load_use_stall_o out  hold PC/IF/ID this cycle (combinational)
//   ex/mem/wb_valid_o out tracking-slot occupancy
//   stall_count_o    out  saturating stall-cycle counter
// Select encoding: 00 regfile, 01 MEM ALU result, 10 WB ALU result,
//                  11 WB load data.
// ============================================================================
module operand_fwd_ctrl #(
    parameter int REG_W   = 5,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_en_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [REG_W-1:0]   id_rs1_i,
    input  logic [REG_W-1:0]   id_rs2_i,
    input  logic               id_rs1_used_i,
    input  logic               id_rs2_used_i,
    input  logic [REG_W-1:0]   id_rd_i,
    input  logic               id_reg_write_i,
    input  logic               id_mem_read_i,
    output logic [1:0]         fwd_sel_a_o,
    output logic [1:0]         fwd_sel_b_o,
    output logic               load_use_stall_o,
    output logic               ex_valid_o,
    output logic               mem_valid_o,
    output logic               wb_valid_o,
    output logic [COUNT_W-1:0] stall_count_o
);

    localparam logic [1:0] SEL_RF       = 2'b00;
    localparam logic [1:0] SEL_MEM_ALU  = 2'b01;
    localparam logic [1:0] SEL_WB_ALU   = 2'b10;
    localparam logic [1:0] SEL_WB_LOAD  = 2'b11;

    localparam logic [REG_W-1:0]   REG_ZERO  = '0;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    slot_t              ex_q,  ex_d;
    slot_t              mem_q, mem_d;
    // Nothing downstream of WB consumes its rd, so only occupancy is kept.
    logic               wb_valid_q, wb_valid_d;
    logic [1:0]         sel_a_q, sel_a_d;
    logic [1:0]         sel_b_q, sel_b_d;
    logic [COUNT_W-1:0] count_q, count_d;

    // A source operand matches a producer slot. x0 never matches, which keeps
    // x0 readers on the register file and out of the stall logic.
    function automatic logic slot_hit(input logic used,
                                      input logic [REG_W-1:0] rs,
                                      input slot_t s);
        slot_hit = used && (rs != REG_ZERO) && s.valid && s.reg_write &&
                   (s.rd == rs);
    endfunction

    // Youngest producer wins: an EX-stage ALU producer beats anything in MEM.
    // An EX-stage load can never be forwarded from here; that case stalls and
    // the consumer re-evaluates once the load reaches MEM.
    function automatic logic [1:0] pick_sel(input logic hit_ex,
                                            input logic hit_mem,
                                            input slot_t ex_s,
                                            input slot_t mem_s);
        if (hit_ex && !ex_s.mem_read) begin
            pick_sel = SEL_MEM_ALU;
        end else if (hit_mem) begin
            pick_sel = mem_s.mem_read ? SEL_WB_LOAD : SEL_WB_ALU;
        end else begin
            pick_sel = SEL_RF;
        end
    endfunction

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic w_rs1_hit_ex, w_rs2_hit_ex;
    logic w_rs1_hit_mem, w_rs2_hit_mem;
    logic w_stall;
    logic w_issue;

    assign w_rs1_hit_ex  = slot_hit(id_rs1_used_i, id_rs1_i, ex_q);
    assign w_rs2_hit_ex  = slot_hit(id_rs2_used_i, id_rs2_i, ex_q);
    assign w_rs1_hit_mem = slot_hit(id_rs1_used_i, id_rs1_i, mem_q);
    assign w_rs2_hit_mem = slot_hit(id_rs2_used_i, id_rs2_i, mem_q);

    // Flush takes precedence: the killed ID instruction must not stall.
    assign w_stall = id_valid_i && !flush_i && ex_q.valid && ex_q.mem_read &&
                     ex_q.reg_write && (ex_q.rd != REG_ZERO) &&
                     (w_rs1_hit_ex || w_rs2_hit_ex);

    assign w_issue = id_valid_i && !flush_i && !w_stall;

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        ex_d       = SLOT_EMPTY;
        mem_d      = ex_q;
        wb_valid_d = mem_q.valid;
        sel_a_d    = SEL_RF;
        sel_b_d    = SEL_RF;
        count_d    = count_q;

        if (flush_i) begin
            mem_d = SLOT_EMPTY;
        end

        if (w_issue) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd_i;
            ex_d.reg_write = id_reg_write_i;
            ex_d.mem_read  = id_mem_read_i;
            sel_a_d        = pick_sel(w_rs1_hit_ex, w_rs1_hit_mem, ex_q, mem_q);
            sel_b_d        = pick_sel(w_rs2_hit_ex, w_rs2_hit_mem, ex_q, mem_q);
        end

        if (w_stall && (count_q != COUNT_MAX)) begin
            count_d = count_q + COUNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // State registers; pipe_en_i low freezes everything.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= SLOT_EMPTY;
            mem_q      <= SLOT_EMPTY;
            wb_valid_q <= 1'b0;
            sel_a_q    <= SEL_RF;
            sel_b_q    <= SEL_RF;
            count_q    <= '0;
        end else if (pipe_en_i) begin
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_valid_q <= wb_valid_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            count_q    <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign fwd_sel_a_o      = sel_a_q;
    assign fwd_sel_b_o      = sel_b_q;
    assign load_use_stall_o = w_stall;
    assign ex_valid_o       = ex_q.valid;
    assign mem_valid_o      = mem_q.valid;
    assign wb_valid_o       = wb_valid_q;
    assign stall_count_o    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fwd_ctrl
// Description : Directed self-checking bench for operand_fwd_ctrl. The stall
//               counter is built narrow so that saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fwd_ctrl;

    localparam int REG_W = 5;
    localparam int CW    = 2;

    logic             clk;
    logic             rst;
    logic             pipe_en;
    logic             flush;
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic [1:0]       fwd_sel_a;
    logic [1:0]       fwd_sel_b;
    logic             load_use_stall;
    logic             ex_valid;
    logic             mem_valid;
    logic             wb_valid;
    logic [CW-1:0]    stall_count;

    int checks = 0;
    int errors = 0;

    operand_fwd_ctrl #(
        .REG_W   (REG_W),
        .COUNT_W (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pipe_en_i        (pipe_en),
        .flush_i          (flush),
        .id_valid_i       (id_valid),
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_rs1_used_i    (id_rs1_used),
        .id_rs2_used_i    (id_rs2_used),
        .id_rd_i          (id_rd),
        .id_reg_write_i   (id_reg_write),
        .id_mem_read_i    (id_mem_read),
        .fwd_sel_a_o      (fwd_sel_a),
        .fwd_sel_b_o      (fwd_sel_b),
        .load_use_stall_o (load_use_stall),
        .ex_valid_o       (ex_valid),
        .mem_valid_o      (mem_valid),
        .wb_valid_o       (wb_valid),
        .stall_count_o    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs1_used  = u1;
        id_rs2       = rs2;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        rst     = 1'b1;
        pipe_en = 1'b1;
        flush   = 1'b0;
        idle();

        // Reset state
        tick();
        tick();
        check("rst_sel_a", 32'(fwd_sel_a), 32'd0);
        check("rst_sel_b", 32'(fwd_sel_b), 32'd0);
        check("rst_stall", 32'(load_use_stall), 32'd0);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_count", 32'(stall_count), 32'd0);

        // Idle cycles after reset keep all slots empty
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd0);
        end

        // Back-to-back ALU: add x5,x1,x2 ; sub x8,x5,x6
        drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        drive(1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0);
        #1;
        check("b2b_no_stall", 32'(load_use_stall), 32'd0);
        tick();
        check("b2b_sel_a", 32'(fwd_sel_a), 32'd1);
        check("b2b_sel_b", 32'(fwd_sel_b), 32'd0);
        check("b2b_valids", {30'd0, ex_valid, mem_valid}, 32'd3);

        // Two-older ALU: add x7 ; nop ; or x10,x1,x7
        drain();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
        tick();
        idle();
        tick();
        drive(1, 5'd1, 1, 5'd7, 1, 5'd10, 1, 0);
        tick();
        check("two_alu_sel_b", 32'(fwd_sel_b), 32'd2);
        check("two_alu_sel_a", 32'(fwd_sel_a), 32'd0);

        // Two-older load: ld x7 ; nop ; or x10,x1,x7
        drain();
        drive(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1);
        tick();
        idle();
        tick();
        drive(1, 5'd1, 1, 5'd7, 1, 5'd10, 1, 0);
        tick();
        check("two_ld_sel_b", 32'(fwd_sel_b), 32'd3);

        // Load-use: ld x3 ; add x4,x3,x3
        drain();
        drive(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1);
        tick();
        drive(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        #1;
        check("lu_stall", 32'(load_use_stall), 32'd1);
        tick();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_mem_ld", 32'(mem_valid), 32'd1);
        check("lu_count", 32'(stall_count), 32'd1);
        check("lu_stall_once", 32'(load_use_stall), 32'd0);
        tick();
        check("lu_sel_a", 32'(fwd_sel_a), 32'd3);
        check("lu_sel_b", 32'(fwd_sel_b), 32'd3);
        check("lu_issued", 32'(ex_valid), 32'd1);
        check("lu_count_hold", 32'(stall_count), 32'd1);

        // x0: ld x0 ; reader of x0
        drain();
        drive(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1);
        tick();
        drive(1, 5'd0, 1, 5'd0, 1, 5'd4, 1, 0);
        #1;
        check("x0_no_stall", 32'(load_use_stall), 32'd0);
        tick();
        check("x0_sel_a", 32'(fwd_sel_a), 32'd0);
        check("x0_sel_b", 32'(fwd_sel_b), 32'd0);
        check("x0_count", 32'(stall_count), 32'd1);

        // Priority: add x9 ; sub x9 ; consumer of x9 on both operands
        drain();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
        tick();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
        tick();
        drive(1, 5'd9, 1, 5'd9, 1, 5'd11, 1, 0);
        tick();
        check("prio_sel_a", 32'(fwd_sel_a), 32'd1);
        check("prio_sel_b", 32'(fwd_sel_b), 32'd1);

        // Flush coinciding with a load-use hazard
        drain();
        drive(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1);
        tick();
        drive(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        flush = 1'b1;
        #1;
        check("flush_no_stall", 32'(load_use_stall), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_ex_valid", 32'(ex_valid), 32'd0);
        check("flush_mem_valid", 32'(mem_valid), 32'd0);
        check("flush_count", 32'(stall_count), 32'd1);

        // Freeze: add x5 ; ld x3,x5 ; add x4,x3 held with pipe_en low
        drain();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        drive(1, 5'd5, 1, 5'd0, 0, 5'd3, 1, 1);
        tick();
        drive(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
        pipe_en = 1'b0;
        #1;
        check("frz_stall", 32'(load_use_stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("frz_sel_a", 32'(fwd_sel_a), 32'd1);
            check("frz_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd6);
            check("frz_count", 32'(stall_count), 32'd1);
            check("frz_stall_held", 32'(load_use_stall), 32'd1);
        end
        pipe_en = 1'b1;
        tick();
        check("thaw_count", 32'(stall_count), 32'd2);
        check("thaw_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd3);
        tick();
        check("thaw_sel_a", 32'(fwd_sel_a), 32'd3);
        check("thaw_ex_valid", 32'(ex_valid), 32'd1);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("arst_sel_a", 32'(fwd_sel_a), 32'd0);
        check("arst_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd0);
        check("arst_count", 32'(stall_count), 32'd0);
        check("arst_stall", 32'(load_use_stall), 32'd0);
        tick();
        rst = 1'b0;

        // Counter saturation
        drain();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1);
            tick();
            drive(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
            tick();
            idle();
            tick();
            check("sat_count", 32'(stall_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
